// File: rtl/mem_arbiter.sv
// Byte-wide RAM port sequencer for the instruction fetch (IF) and load/store buffer (LS) requesters.
// Latency: read of N bytes gives done N+1 cycles after the grant edge; write of N bytes gives done N cycles after it.
// Backpressure: requests are held until done, IO stores wait while io_buffer_full=1, and rdy=0 freezes every register.
//
// Ports:
//   clk, reset (async, active-high), rdy (global enable)
//   if_req/if_addr -> if_done/if_data             : 32-bit little-endian fetch
//   ls_req/ls_wr/ls_addr/ls_size/ls_wdata -> ls_done/ls_rdata : 1/2/4-byte load/store
//   flush                                          : aborts an in-flight fetch
//   io_buffer_full                                 : blocks stores to addresses >= IO_BASE
//   mem_wr/mem_a/mem_dout/mem_din                  : byte-wide RAM/IO port (mem_din one cycle after mem_a)
module mem_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 'h30000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rdy,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  ls_req,
    input  logic                  ls_wr,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [1:0]            ls_size,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata,
    input  logic                  flush,
    input  logic                  io_buffer_full,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [7:0]            mem_dout,
    input  logic [7:0]            mem_din
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // Registered state
    state_t                state_q,    state_n;
    logic                  owner_q,    owner_n;
    logic                  last_ls_q,  last_ls_n;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_n;
    logic [2:0]            nb_q,       nb_n;
    logic [2:0]            cnt_q,      cnt_n;
    logic [31:0]           wdata_q,    wdata_n;
    logic [31:0]           rbuf_q,     rbuf_n;
    logic [ADDR_WIDTH-1:0] mem_a_q,    mem_a_n;
    logic [7:0]            mem_dout_q, mem_dout_n;
    logic                  mem_wr_q,   mem_wr_n;
    logic                  if_done_q,  if_done_n;
    logic [31:0]           if_data_q,  if_data_n;
    logic                  ls_done_q,  ls_done_n;
    logic [31:0]           ls_rdata_q, ls_rdata_n;

    // The RAM keeps reading while we are frozen, so the byte that was on
    // mem_din when the freeze began would be overwritten by the time we
    // resume. Keep a copy and use it on the first edge after the freeze.
    logic                  stall_q;
    logic [7:0]            din_sav_q;
    logic [7:0]            din_eff;

    logic [1:0]            lane_rd;
    logic [1:0]            lane_wr;
    logic [31:0]           rbuf_cap;
    logic [7:0]            wbyte_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  ls_io_blocked;
    logic                  if_elig;
    logic                  ls_elig;
    logic                  grant_ls;
    logic                  grant_if;
    logic [2:0]            ls_nb;

    always_comb begin
        din_eff       = stall_q ? din_sav_q : mem_din;
        // Byte arriving now belongs to the address issued one cycle earlier.
        lane_rd       = cnt_q[1:0] - 2'd1;
        lane_wr       = cnt_q[1:0] + 2'd1;
        rbuf_cap      = rbuf_q | ({24'h0, din_eff} << {lane_rd, 3'b000});
        addr_next     = addr_q + ADDR_WIDTH'(cnt_q + 3'd1);
        case (lane_wr)
            2'd0:    wbyte_next = wdata_q[7:0];
            2'd1:    wbyte_next = wdata_q[15:8];
            2'd2:    wbyte_next = wdata_q[23:16];
            default: wbyte_next = wdata_q[31:24];
        endcase
        case (ls_size)
            2'b00:   ls_nb = 3'd1;
            2'b01:   ls_nb = 3'd2;
            default: ls_nb = 3'd4;
        endcase
        // A requester sees its done pulse in the same cycle it drops req,
        // so a still-high req during done must not start a second access.
        ls_io_blocked = ls_wr && (ls_addr >= IO_BASE) && io_buffer_full;
        if_elig       = if_req && !if_done_q && !flush;
        ls_elig       = ls_req && !ls_done_q && !ls_io_blocked;
        grant_ls      = ls_elig && (!if_elig || !last_ls_q);
        grant_if      = if_elig && !grant_ls;
    end

    always_comb begin
        state_n    = state_q;
        owner_n    = owner_q;
        last_ls_n  = last_ls_q;
        addr_n     = addr_q;
        nb_n       = nb_q;
        cnt_n      = cnt_q;
        wdata_n    = wdata_q;
        rbuf_n     = rbuf_q;
        mem_a_n    = mem_a_q;
        mem_dout_n = mem_dout_q;
        mem_wr_n   = 1'b0;
        if_done_n  = 1'b0;
        if_data_n  = if_data_q;
        ls_done_n  = 1'b0;
        ls_rdata_n = ls_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_ls) begin
                    owner_n   = OWN_LS;
                    last_ls_n = 1'b1;
                    addr_n    = ls_addr;
                    nb_n      = ls_nb;
                    wdata_n   = ls_wdata;
                    rbuf_n    = 32'h0;
                    cnt_n     = 3'd0;
                    mem_a_n   = ls_addr;
                    if (ls_wr) begin
                        state_n    = WRITE;
                        mem_wr_n   = 1'b1;
                        mem_dout_n = ls_wdata[7:0];
                    end else begin
                        state_n = READ;
                    end
                end else if (grant_if) begin
                    owner_n   = OWN_IF;
                    last_ls_n = 1'b0;
                    addr_n    = if_addr;
                    nb_n      = 3'd4;
                    rbuf_n    = 32'h0;
                    cnt_n     = 3'd0;
                    mem_a_n   = if_addr;
                    state_n   = READ;
                end
            end

            READ: begin
                if (owner_q == OWN_IF && flush) begin
                    // Drop the fetch silently; if_data keeps its old value.
                    state_n = IDLE;
                    cnt_n   = 3'd0;
                end else begin
                    if (cnt_q != 3'd0)
                        rbuf_n = rbuf_cap;
                    if (cnt_q == nb_q) begin
                        state_n = IDLE;
                        cnt_n   = 3'd0;
                        if (owner_q == OWN_IF) begin
                            if_done_n = 1'b1;
                            if_data_n = rbuf_cap;
                        end else begin
                            ls_done_n  = 1'b1;
                            ls_rdata_n = rbuf_cap;
                        end
                    end else begin
                        cnt_n = cnt_q + 3'd1;
                        // Last address stays on mem_a while the final byte returns.
                        if ((cnt_q + 3'd1) < nb_q)
                            mem_a_n = addr_next;
                    end
                end
            end

            WRITE: begin
                if (cnt_q == nb_q - 3'd1) begin
                    state_n   = IDLE;
                    cnt_n     = 3'd0;
                    ls_done_n = 1'b1;
                end else begin
                    cnt_n      = cnt_q + 3'd1;
                    mem_a_n    = addr_next;
                    mem_dout_n = wbyte_next;
                    mem_wr_n   = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            last_ls_q  <= 1'b0;
            addr_q     <= '0;
            nb_q       <= 3'd0;
            cnt_q      <= 3'd0;
            wdata_q    <= 32'h0;
            rbuf_q     <= 32'h0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'h0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            if_data_q  <= 32'h0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= 32'h0;
            stall_q    <= 1'b0;
            din_sav_q  <= 8'h0;
        end else begin
            stall_q <= !rdy;
            if (!rdy && !stall_q)
                din_sav_q <= mem_din;
            if (rdy) begin
                state_q    <= state_n;
                owner_q    <= owner_n;
                last_ls_q  <= last_ls_n;
                addr_q     <= addr_n;
                nb_q       <= nb_n;
                cnt_q      <= cnt_n;
                wdata_q    <= wdata_n;
                rbuf_q     <= rbuf_n;
                mem_a_q    <= mem_a_n;
                mem_dout_q <= mem_dout_n;
                mem_wr_q   <= mem_wr_n;
                if_done_q  <= if_done_n;
                if_data_q  <= if_data_n;
                ls_done_q  <= ls_done_n;
                ls_rdata_q <= ls_rdata_n;
            end
        end
    end

    assign mem_wr   = mem_wr_q && rdy;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a byte-wide RAM model (read data one cycle after address).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises io_buffer_full gating, rdy freeze, flush abort and requester contention.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [1:0]  ls_size;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        flush;
    logic        io_buffer_full;
    logic        mem_wr;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:65535];

    mem_arbiter #(.ADDR_WIDTH(32), .IO_BASE(32'h30000)) dut (
        .clk(clk), .reset(reset), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .flush(flush), .io_buffer_full(io_buffer_full),
        .mem_wr(mem_wr), .mem_a(mem_a), .mem_dout(mem_dout), .mem_din(mem_din)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: 64 KiB aliased, synchronous read, write on mem_wr.
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
        ram[16'h0100] <= 8'h11;
        ram[16'h0101] <= 8'h22;
        ram[16'h0102] <= 8'h33;
        ram[16'h0103] <= 8'h44;
        ram[16'h0205] <= 8'h77;
        ram[16'h0300] <= 8'hFE;
        ram[16'h0301] <= 8'h80;
    end

    always @(posedge clk) begin
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; rdy = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_addr = 32'h0; ls_size = 2'b00; ls_wdata = 32'h0;
        flush = 1'b0; io_buffer_full = 1'b0;
        #2;
        chk("rst_mem_wr",   {31'h0, mem_wr},  32'h0);
        chk("rst_mem_a",    mem_a,            32'h0);
        chk("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
        chk("rst_if_done",  {31'h0, if_done}, 32'h0);
        chk("rst_ls_done",  {31'h0, ls_done}, 32'h0);
        chk("rst_if_data",  if_data,          32'h0);
        chk("rst_ls_rdata", ls_rdata,         32'h0);
        tick; tick;
        reset = 1'b0;

        // Word fetch at 0x100
        if_req = 1'b1; if_addr = 32'h100;
        tick; chk("fetch_c0_a", mem_a, 32'h100);
        chk("fetch_c0_wr", {31'h0, mem_wr}, 32'h0);
        tick; chk("fetch_c1_a", mem_a, 32'h101);
        tick; chk("fetch_c2_a", mem_a, 32'h102);
        tick; chk("fetch_c3_a", mem_a, 32'h103);
        tick; chk("fetch_c4_done", {31'h0, if_done}, 32'h0);
        tick; chk("fetch_c5_done", {31'h0, if_done}, 32'h1);
        chk("fetch_data", if_data, 32'h44332211);
        if_req = 1'b0;
        tick; chk("fetch_pulse_end", {31'h0, if_done}, 32'h0);

        // Contention: last grant was IF, so LS goes first, then IF, then LS
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b00; ls_addr = 32'h300;
        tick; chk("cont_ls1_a", mem_a, 32'h300);
        tick;
        tick; chk("cont_ls1_done", {31'h0, ls_done}, 32'h1);
        chk("cont_ls1_data", ls_rdata, 32'h000000FE);
        chk("cont_ls1_ifdone", {31'h0, if_done}, 32'h0);
        tick; chk("cont_if_a", mem_a, 32'h100);
        chk("cont_if_lsdone", {31'h0, ls_done}, 32'h0);
        tick; tick; tick; tick;
        tick; chk("cont_if_done", {31'h0, if_done}, 32'h1);
        if_req = 1'b0;
        tick; chk("cont_ls2_a", mem_a, 32'h300);
        tick;
        tick; chk("cont_ls2_done", {31'h0, ls_done}, 32'h1);
        ls_req = 1'b0;
        tick;

        // Byte store to 0x204
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b00; ls_addr = 32'h204; ls_wdata = 32'hABCDEF5A;
        tick; chk("stb_wr", {31'h0, mem_wr}, 32'h1);
        chk("stb_a", mem_a, 32'h204);
        chk("stb_dout", {24'h0, mem_dout}, 32'h5A);
        tick; chk("stb_done", {31'h0, ls_done}, 32'h1);
        chk("stb_wr_off", {31'h0, mem_wr}, 32'h0);
        chk("stb_ram204", {24'h0, ram[16'h0204]}, 32'h5A);
        chk("stb_ram205", {24'h0, ram[16'h0205]}, 32'h77);
        ls_req = 1'b0; ls_wr = 1'b0;
        tick;

        // Half load from 0x300
        ls_req = 1'b1; ls_size = 2'b01; ls_addr = 32'h300;
        tick; chk("ldh_c0_a", mem_a, 32'h300);
        tick; chk("ldh_c1_a", mem_a, 32'h301);
        tick; chk("ldh_c2_done", {31'h0, ls_done}, 32'h0);
        tick; chk("ldh_c3_done", {31'h0, ls_done}, 32'h1);
        chk("ldh_data", ls_rdata, 32'h000080FE);
        ls_req = 1'b0;
        tick;

        // Flush during fetch, LS pending (last grant LS -> IF wins first)
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b00; ls_addr = 32'h300;
        tick; chk("fl_if_a", mem_a, 32'h100);
        tick;
        tick; chk("fl_c2_a", mem_a, 32'h102);
        flush = 1'b1; if_req = 1'b0;
        tick; chk("fl_no_done", {31'h0, if_done}, 32'h0);
        chk("fl_a_hold", mem_a, 32'h102);
        flush = 1'b0;
        tick; chk("fl_ls_a", mem_a, 32'h300);
        tick;
        tick; chk("fl_ls_done", {31'h0, ls_done}, 32'h1);
        chk("fl_ls_data", ls_rdata, 32'h000000FE);
        chk("fl_if_data_kept", if_data, 32'h44332211);
        ls_req = 1'b0;
        tick;

        // IO store gated by io_buffer_full
        io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b00; ls_addr = 32'h30000; ls_wdata = 32'h00000099;
        tick; chk("io_block1", {31'h0, mem_wr}, 32'h0);
        tick; chk("io_block2", {31'h0, mem_wr}, 32'h0);
        tick; chk("io_block3", {31'h0, mem_wr}, 32'h0);
        io_buffer_full = 1'b0;
        tick; chk("io_wr", {31'h0, mem_wr}, 32'h1);
        chk("io_a", mem_a, 32'h30000);
        chk("io_dout", {24'h0, mem_dout}, 32'h99);
        tick; chk("io_done", {31'h0, ls_done}, 32'h1);
        ls_req = 1'b0; ls_wr = 1'b0;
        tick;

        // rdy freeze for 3 cycles in the middle of a fetch
        if_req = 1'b1; if_addr = 32'h100;
        tick;
        tick; chk("stall_c1_a", mem_a, 32'h101);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick; chk("stall_a_hold", mem_a, 32'h101);
            chk("stall_no_done", {31'h0, if_done}, 32'h0);
        end
        rdy = 1'b1;
        tick; chk("stall_c2_a", mem_a, 32'h102);
        tick; tick;
        tick; chk("stall_done", {31'h0, if_done}, 32'h1);
        chk("stall_data", if_data, 32'h44332211);
        if_req = 1'b0;
        tick;

        // Address wrap at the top of the address space
        if_req = 1'b1; if_addr = 32'hFFFFFFFE;
        tick; chk("wrap_c0_a", mem_a, 32'hFFFFFFFE);
        tick; chk("wrap_c1_a", mem_a, 32'hFFFFFFFF);
        tick; chk("wrap_c2_a", mem_a, 32'h00000000);
        tick; chk("wrap_c3_a", mem_a, 32'h00000001);
        tick;
        tick; chk("wrap_done", {31'h0, if_done}, 32'h1);
        chk("wrap_data", if_data, 32'h00990000);
        if_req = 1'b0;
        tick;

        // Word store, combinational mem_wr mask, then reset mid-write
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b10; ls_addr = 32'h400; ls_wdata = 32'h11223344;
        tick; chk("stw_c0_wr", {31'h0, mem_wr}, 32'h1);
        chk("stw_c0_dout", {24'h0, mem_dout}, 32'h44);
        rdy = 1'b0; #1;
        chk("stw_rdy_mask", {31'h0, mem_wr}, 32'h0);
        rdy = 1'b1; #1;
        chk("stw_rdy_unmask", {31'h0, mem_wr}, 32'h1);
        tick; chk("stw_c1_a", mem_a, 32'h401);
        chk("stw_c1_dout", {24'h0, mem_dout}, 32'h33);
        #2 reset = 1'b1;
        #1;
        chk("rstw_wr", {31'h0, mem_wr}, 32'h0);
        chk("rstw_a", mem_a, 32'h0);
        chk("rstw_dout", {24'h0, mem_dout}, 32'h0);
        ls_req = 1'b0; ls_wr = 1'b0;
        tick;
        reset = 1'b0;
        tick; chk("rstw_idle_wr", {31'h0, mem_wr}, 32'h0);
        chk("rstw_idle_a", mem_a, 32'h0);
        chk("rstw_idle_done", {31'h0, ls_done}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM port between two requesters.
  - Instruction fetch: always 32-bit reads.
  - Load/store buffer: 1/2/4-byte reads and writes.
- Splits each request into per-byte RAM cycles and assembles little-endian words.
- Returns a one-cycle done pulse to the requester.
- Sits between the IF/LSB units and the top-level RAM/IO interface.

Parameters:
- ADDR_WIDTH, 32, width of all addresses.
- IO_BASE, 32'h30000, addresses >= IO_BASE are IO-mapped and gated by io_buffer_full.

Ports:
- clk  in  1  system clock; everything on posedge.
- reset  in  1  asynchronous active-high reset.
- rdy  in  1  global enable; 0 freezes the block.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_done  out  1  one-cycle pulse; if_data valid this cycle.
- if_data  out  32  fetched word, little-endian.
- ls_req  in  1  load/store request; held until ls_done.
- ls_wr  in  1  1=store, 0=load.
- ls_addr  in  ADDR_WIDTH  load/store byte address.
- ls_size  in  2  00=byte, 01=half, 10/11=word.
- ls_wdata  in  32  store data; low bytes used.
- ls_done  out  1  one-cycle pulse; ls_rdata valid on loads.
- ls_rdata  out  32  load data, zero-extended (sign extension done by LSB).
- flush  in  1  mispredict; aborts in-flight fetch.
- io_buffer_full  in  1  IO write buffer full.
- mem_wr  out  1  RAM write enable.
- mem_a  out  ADDR_WIDTH  RAM byte address.
- mem_dout  out  8  RAM write byte.
- mem_din  in  8  RAM read byte; valid the cycle after its address was driven.

Behaviour:
- Reset (async, any state): state=IDLE, byte counters=0, all outputs 0 (mem_wr, mem_a, mem_dout, if_done, ls_done, if_data, ls_rdata).
- rdy=0: all registers hold, mem_wr is masked to 0 combinationally. On rdy=1, operation resumes exactly where it stopped.
- States: IDLE, READ, WRITE. Owner register = IF or LS.
- IDLE grant rules, evaluated each posedge:
  - A requester whose done is high this cycle is ignored (requester drops req on its done cycle).
  - A store with ls_addr >= IO_BASE while io_buffer_full=1 is not eligible; IF may still be granted.
  - IF is not eligible while flush=1.
  - If both are eligible, LS wins unless the last grant was LS. This alternates, so neither requester can starve.
- Grant edge:
  - Latch address A, byte count N (1/2/4), write data and owner.
  - Go to READ or WRITE.
  - Cycle C0 drives mem_a=A; for writes also mem_wr=1 and mem_dout=byte0.
- READ:
  - Cycle Ck (k=0..N-1) drives mem_a=A+k, mem_wr=0.
  - At the edge ending C(k+1), mem_din is captured into bits [8k+7:8k]; unused upper bytes are 0.
  - At the edge ending CN, done and data are registered and state returns to IDLE.
  - done is high in C(N+1): N+1 cycles after the grant edge.
- WRITE:
  - Cycle Ck drives mem_wr=1, mem_a=A+k, mem_dout=wdata[8k+7:8k].
  - At the edge ending C(N-1), go to IDLE and set ls_done.
  - In CN: ls_done=1, mem_wr=0.
- Address arithmetic: A+k wraps modulo 2^ADDR_WIDTH.
- mem_a holds its last value in IDLE; mem_wr=0 in IDLE.
- flush:
  - IF read in flight: returns to IDLE at the next edge; if_done is not asserted and if_data is unchanged.
  - LS operations are never aborted by flush.
- Done pulses last exactly one cycle. if_done and ls_done are never high together.

Test Plan:
- Word fetch: RAM[0x100..0x103]=11,22,33,44, if_req at 0x100 -> mem_a 0x100..0x103 in C0..C3, if_done in C5 with if_data=0x44332211.
- Byte store: ls_wr=1, size=00, addr 0x204, wdata 0xABCDEF5A -> single cycle mem_wr=1, mem_a=0x204, mem_dout=0x5A; ls_done next cycle; RAM[0x205] untouched.
- Half load: RAM[0x300]=0xFE, RAM[0x301]=0x80 -> ls_rdata=0x000080FE, ls_done 3 cycles after grant.
- Contention: if_req and ls_req held continuously -> grants alternate LS, IF, LS, with one IDLE cycle between operations.
- Flush: flush at C2 of a fetch -> IDLE next cycle, no if_done; a pending ls_req is granted on the following edge.
- IO gating and freeze:
  - Store to 0x30000 with io_buffer_full=1 -> no mem_wr until full drops.
  - rdy=0 mid-read for 3 cycles -> mem_a held, result identical to the unstalled run.
  - reset pulse mid-write -> mem_wr=0 immediately, state IDLE.
